// File: rtl/sde_trig_sched_if.sv
// Trigger scheduler bus: trigger sources, mask and dead-time configuration in,
// buffer-write trigger, source snapshot and statistics counters out.
interface sde_trig_sched_if #(
   parameter int NSRC     = 8,
   parameter int SRC_BITS = 3
);
   logic [NSRC-1:0]     src_trig;
   logic [NSRC-1:0]     src_mask;
   logic [15:0]         deadtime;
   logic                buf_full;
   logic                cnt_clr;
   logic                trig_out;
   logic [NSRC-1:0]     trig_src;
   logic [SRC_BITS-1:0] trig_prio;
   logic                busy;
   logic [31:0]         trig_cnt;
   logic [15:0]         drop_cnt;

   modport master (
      output src_trig, src_mask, deadtime, buf_full, cnt_clr,
      input  trig_out, trig_src, trig_prio, busy, trig_cnt, drop_cnt
   );

   modport slave (
      input  src_trig, src_mask, deadtime, buf_full, cnt_clr,
      output trig_out, trig_src, trig_prio, busy, trig_cnt, drop_cnt
   );
endinterface

// File: rtl/sde_trig_sched.sv
// SDE trigger scheduler: merges masked trigger pulses into single buffer-write triggers
// with buffer-full backpressure, programmable dead time and issued/dropped counters.
module sde_trig_sched #(
   parameter int NSRC     = 8,
   parameter int SRC_BITS = 3,
   parameter int WAIT_MAX = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   sde_trig_sched_if.slave        bus
);

   localparam int WBITS = $clog2(WAIT_MAX + 1);
   localparam logic [WBITS-1:0] WAIT_LIM = WBITS'(WAIT_MAX);

   typedef enum logic [1:0] {IDLE, WAIT, FIRE, DEAD} state_t;

   state_t              state, state_next;
   logic [NSRC-1:0]     pend, pend_next;
   logic                trig_out_r, trig_out_next;
   logic [NSRC-1:0]     trig_src_r, trig_src_next;
   logic [SRC_BITS-1:0] trig_prio_r, trig_prio_next;
   logic                busy_r, busy_next;
   logic [31:0]         trig_cnt_r, trig_cnt_next;
   logic [15:0]         drop_cnt_r, drop_cnt_next;
   logic [WBITS-1:0]    wait_cnt, wait_next;
   logic [15:0]         dead_cnt, dead_next;
   logic                trig_inc, drop_inc;
   logic [NSRC-1:0]     hit, merged;

   function automatic logic [SRC_BITS-1:0] low_index(input logic [NSRC-1:0] v);
      low_index = '0;
      for (int i = NSRC - 1; i >= 0; i--)
         if (v[i]) low_index = SRC_BITS'(i);
   endfunction

   assign hit    = bus.src_trig & bus.src_mask;
   assign merged = (pend | hit) & bus.src_mask;

   always_comb begin
      state_next     = state;
      pend_next      = pend;
      trig_out_next  = 1'b0;
      trig_src_next  = trig_src_r;
      trig_prio_next = trig_prio_r;
      wait_next      = wait_cnt;
      dead_next      = dead_cnt;
      trig_inc       = 1'b0;
      drop_inc       = 1'b0;

      case (state)
         IDLE: begin
            if (hit != '0) begin
               if (!bus.buf_full) begin
                  state_next     = FIRE;
                  trig_out_next  = 1'b1;
                  trig_src_next  = hit;
                  trig_prio_next = low_index(hit);
               end else begin
                  state_next = WAIT;
                  pend_next  = hit;
                  wait_next  = WBITS'(1);
               end
            end
         end
         // A mask cleared while waiting silently abandons the pending trigger.
         WAIT: begin
            pend_next = pend | hit;
            if (merged == '0) begin
               state_next = IDLE;
               pend_next  = '0;
            end else if (!bus.buf_full) begin
               state_next     = FIRE;
               trig_out_next  = 1'b1;
               trig_src_next  = merged;
               trig_prio_next = low_index(merged);
               pend_next      = '0;
            end else if (wait_cnt == WAIT_LIM) begin
               state_next = IDLE;
               pend_next  = '0;
               drop_inc   = 1'b1;
            end else begin
               wait_next = wait_cnt + 1'b1;
            end
         end
         FIRE: begin
            trig_inc = 1'b1;
            drop_inc = (hit != '0);
            if (bus.deadtime == 16'd0) begin
               state_next = IDLE;
            end else begin
               state_next = DEAD;
               dead_next  = bus.deadtime;
            end
         end
         DEAD: begin
            drop_inc = (hit != '0);
            if (dead_cnt <= 16'd1) begin
               state_next = IDLE;
               dead_next  = 16'd0;
            end else begin
               dead_next = dead_cnt - 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);

      // Clear takes precedence over a coincident increment.
      if (bus.cnt_clr)
         trig_cnt_next = 32'd0;
      else if (trig_inc)
         trig_cnt_next = trig_cnt_r + 32'd1;
      else
         trig_cnt_next = trig_cnt_r;

      if (bus.cnt_clr)
         drop_cnt_next = 16'd0;
      else if (drop_inc && drop_cnt_r != 16'hFFFF)
         drop_cnt_next = drop_cnt_r + 16'd1;
      else
         drop_cnt_next = drop_cnt_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pend        <= '0;
         trig_out_r  <= 1'b0;
         trig_src_r  <= '0;
         trig_prio_r <= '0;
         busy_r      <= 1'b0;
         trig_cnt_r  <= 32'd0;
         drop_cnt_r  <= 16'd0;
         wait_cnt    <= '0;
         dead_cnt    <= 16'd0;
      end else begin
         state       <= state_next;
         pend        <= pend_next;
         trig_out_r  <= trig_out_next;
         trig_src_r  <= trig_src_next;
         trig_prio_r <= trig_prio_next;
         busy_r      <= busy_next;
         trig_cnt_r  <= trig_cnt_next;
         drop_cnt_r  <= drop_cnt_next;
         wait_cnt    <= wait_next;
         dead_cnt    <= dead_next;
      end
   end

   assign bus.trig_out  = trig_out_r;
   assign bus.trig_src  = trig_src_r;
   assign bus.trig_prio = trig_prio_r;
   assign bus.busy      = busy_r;
   assign bus.trig_cnt  = trig_cnt_r;
   assign bus.drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_sde_trig_sched.sv
// Directed bench for sde_trig_sched: latency, merging, dead time, backpressure,
// timeout, masking, counter saturation/clear and mid-operation reset.
module tb_sde_trig_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   sde_trig_sched_if #(.NSRC(8), .SRC_BITS(3)) bus ();

   sde_trig_sched #(.NSRC(8), .SRC_BITS(3), .WAIT_MAX(256)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] v);
      bus.src_trig = v;
      tick();
      bus.src_trig = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.src_trig = 8'h00;
      bus.cnt_clr  = 1'b0;
      bus.buf_full = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.trig_out !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got out=%b busy=%b expected 0 0", bus.trig_out, bus.busy);
      end
      checks++;
      if (bus.trig_src !== 8'h00 || bus.trig_prio !== 3'd0 || bus.trig_cnt !== 32'd0 || bus.drop_cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_data: got src=%h prio=%0d tc=%0d dc=%0d expected all 0",
                  bus.trig_src, bus.trig_prio, bus.trig_cnt, bus.drop_cnt);
      end
   endtask

   task automatic test_single_fire();
      bus.src_mask = 8'hFF;
      bus.deadtime = 16'd0;
      pulse(8'h04);
      checks++;
      if (bus.trig_out !== 1'b1 || bus.trig_src !== 8'h04 || bus.trig_prio !== 3'd2) begin
         errors++;
         $display("[TB] FAIL single_fire: got out=%b src=%h prio=%0d expected 1 04 2",
                  bus.trig_out, bus.trig_src, bus.trig_prio);
      end
      tick();
      checks++;
      if (bus.trig_out !== 1'b0 || bus.trig_cnt !== 32'd1) begin
         errors++;
         $display("[TB] FAIL single_after: got out=%b cnt=%0d expected 0 1", bus.trig_out, bus.trig_cnt);
      end
   endtask

   task automatic test_dead_time();
      int first = 0;
      do_reset();
      bus.src_mask = 8'hFF;
      bus.deadtime = 16'd10;
      pulse(8'h0B);
      checks++;
      if (bus.trig_out !== 1'b1 || bus.trig_src !== 8'h0B || bus.trig_prio !== 3'd0) begin
         errors++;
         $display("[TB] FAIL dead_first: got out=%b src=%h prio=%0d expected 1 0b 0",
                  bus.trig_out, bus.trig_src, bus.trig_prio);
      end
      for (int n = 1; n <= 14; n++) begin
         bus.src_trig = (n == 3 || n == 8 || n >= 9) ? 8'h01 : 8'h00;
         tick();
         if (bus.trig_out === 1'b1 && first == 0) first = n;
         if (n == 8) begin
            checks++;
            if (bus.drop_cnt !== 16'd2) begin
               errors++;
               $display("[TB] FAIL dead_drops: got %0d expected 2", bus.drop_cnt);
            end
         end
      end
      bus.src_trig = 8'h00;
      checks++;
      if (first != 12) begin
         errors++;
         $display("[TB] FAIL dead_spacing: got next fire at +%0d expected +12", first);
      end
      checks++;
      if (bus.drop_cnt !== 16'd7 || bus.trig_cnt !== 32'd2) begin
         errors++;
         $display("[TB] FAIL dead_totals: got drops=%0d trigs=%0d expected 7 2", bus.drop_cnt, bus.trig_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int fires = 0;
      int adjacent = 0;
      logic prev = 1'b0;
      do_reset();
      bus.src_mask = 8'hFF;
      bus.deadtime = 16'd0;
      bus.src_trig = 8'h01;
      for (int n = 1; n <= 6; n++) begin
         tick();
         if (bus.trig_out === 1'b1) begin
            fires++;
            if (prev) adjacent++;
         end
         prev = (bus.trig_out === 1'b1);
      end
      bus.src_trig = 8'h00;
      checks++;
      if (fires != 3 || adjacent != 0) begin
         errors++;
         $display("[TB] FAIL back_to_back: got fires=%0d adjacent=%0d expected 3 0", fires, adjacent);
      end
   endtask

   task automatic test_wait_merge();
      int fires = 0;
      logic [7:0] src = 8'h00;
      logic [2:0] prio = 3'd0;
      do_reset();
      bus.src_mask = 8'hFF;
      bus.deadtime = 16'd0;
      bus.buf_full = 1'b1;
      pulse(8'h02);
      for (int n = 1; n <= 25; n++) begin
         bus.src_trig = (n == 3) ? 8'h10 : 8'h00;
         if (n == 20) bus.buf_full = 1'b0;
         tick();
         if (n == 5) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.trig_out !== 1'b0) begin
               errors++;
               $display("[TB] FAIL wait_busy: got busy=%b out=%b expected 1 0", bus.busy, bus.trig_out);
            end
         end
         if (bus.trig_out === 1'b1) begin
            fires++;
            src  = bus.trig_src;
            prio = bus.trig_prio;
         end
      end
      checks++;
      if (fires != 1 || src !== 8'h12 || prio !== 3'd1 || bus.drop_cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL wait_merge: got fires=%0d src=%h prio=%0d drops=%0d expected 1 12 1 0",
                  fires, src, prio, bus.drop_cnt);
      end
   endtask

   task automatic test_wait_timeout();
      int fires = 0;
      int idle_at = 0;
      do_reset();
      bus.src_mask = 8'hFF;
      bus.buf_full = 1'b1;
      pulse(8'h01);
      for (int n = 1; n <= 300; n++) begin
         tick();
         if (bus.trig_out === 1'b1) fires++;
         if (bus.busy === 1'b0 && idle_at == 0) idle_at = n;
      end
      bus.buf_full = 1'b0;
      checks++;
      if (idle_at != 256) begin
         errors++;
         $display("[TB] FAIL timeout_idle: got busy low at +%0d expected +256", idle_at);
      end
      checks++;
      if (fires != 0 || bus.drop_cnt !== 16'd1) begin
         errors++;
         $display("[TB] FAIL timeout_drop: got fires=%0d drops=%0d expected 0 1", fires, bus.drop_cnt);
      end
   endtask

   task automatic test_mask();
      int fires = 0;
      do_reset();
      bus.src_mask = 8'hFE;
      pulse(8'h01);
      for (int n = 1; n <= 4; n++) begin
         tick();
         if (bus.trig_out === 1'b1) fires++;
      end
      checks++;
      if (fires != 0 || bus.drop_cnt !== 16'd0 || bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mask_ignore: got fires=%0d drops=%0d busy=%b expected 0 0 0",
                  fires, bus.drop_cnt, bus.busy);
      end
      bus.src_mask = 8'hFF;
   endtask

   task automatic test_saturate_and_clear();
      do_reset();
      bus.src_mask = 8'hFF;
      bus.deadtime = 16'hFFFF;
      bus.src_trig = 8'h01;
      for (int n = 1; n <= 65537; n++) begin
         tick();
         if (n == 65535) begin
            checks++;
            if (bus.drop_cnt !== 16'hFFFE) begin
               errors++;
               $display("[TB] FAIL sat_preload: got %h expected fffe", bus.drop_cnt);
            end
         end
      end
      bus.src_trig = 8'h00;
      checks++;
      if (bus.drop_cnt !== 16'hFFFF || bus.trig_cnt !== 32'd1) begin
         errors++;
         $display("[TB] FAIL sat_hold: got drops=%h trigs=%0d expected ffff 1", bus.drop_cnt, bus.trig_cnt);
      end
      bus.deadtime = 16'd0;
      pulse(8'h01);
      checks++;
      if (bus.trig_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL clr_fire: got out=%b expected 1", bus.trig_out);
      end
      bus.cnt_clr = 1'b1;
      tick();
      bus.cnt_clr = 1'b0;
      checks++;
      if (bus.trig_cnt !== 32'd0 || bus.drop_cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL clr_wins: got trigs=%0d drops=%0d expected 0 0", bus.trig_cnt, bus.drop_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int fires = 0;
      do_reset();
      bus.src_mask = 8'hFF;
      bus.deadtime = 16'd10;
      pulse(8'h01);
      for (int n = 1; n <= 4; n++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.trig_cnt !== 32'd0 || bus.trig_src !== 8'h00) begin
         errors++;
         $display("[TB] FAIL rst_dead: got busy=%b trigs=%0d src=%h expected 0 0 00",
                  bus.busy, bus.trig_cnt, bus.trig_src);
      end
      bus.buf_full = 1'b1;
      pulse(8'h01);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.buf_full = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.drop_cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL rst_wait: got busy=%b drops=%0d expected 0 0", bus.busy, bus.drop_cnt);
      end
      for (int n = 1; n <= 4; n++) begin
         tick();
         if (bus.trig_out === 1'b1) fires++;
      end
      checks++;
      if (fires != 0) begin
         errors++;
         $display("[TB] FAIL rst_no_fire: got %0d fires expected 0", fires);
      end
      pulse(8'h20);
      checks++;
      if (bus.trig_out !== 1'b1 || bus.trig_src !== 8'h20 || bus.trig_prio !== 3'd5) begin
         errors++;
         $display("[TB] FAIL rst_fresh: got out=%b src=%h prio=%0d expected 1 20 5",
                  bus.trig_out, bus.trig_src, bus.trig_prio);
      end
   endtask

   initial begin
      bus.src_trig = 8'h00;
      bus.src_mask = 8'hFF;
      bus.deadtime = 16'd0;
      bus.buf_full = 1'b0;
      bus.cnt_clr  = 1'b0;
      $display("[TB] starting sde_trig_sched bench");
      test_reset();
      test_single_fire();
      test_dead_time();
      test_back_to_back();
      test_wait_merge();
      test_wait_timeout();
      test_mask();
      test_saturate_and_clear();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
